// File: rtl/sample_frontend_pkg.sv
// Shared types and constants for the sample_frontend capture block.
// The 32-bit sample word is {event, delta, data}, with the event flag in the MSB.
package sample_frontend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int SF_DATA_W      = 24;
    localparam int SF_DELTA_W     = 7;
    localparam int SF_SYNC_STAGES = 2;

    localparam int EVT_BIT   = 31;
    localparam int DELTA_LSB = SF_DATA_W;

    function automatic int delta_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int DMAX = delta_max(SF_DELTA_W);

endpackage

// File: rtl/sample_frontend_sync.sv
// Multi-stage flop chain that brings the asynchronous pin bus into the clk domain.
// There is deliberately no logic between stages.
module bit_sync #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/sample_frontend.sv
// Capture front-end: synchronises the pin bus, waits for a masked trigger, then emits
// one timestamped {event, delta, data} word per clock to the sampler.
module sample_frontend
    import sample_frontend_pkg::*;
#(
    parameter int DATA_W      = SF_DATA_W,
    parameter int DELTA_W     = SF_DELTA_W,
    parameter int SYNC_STAGES = SF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              active,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [15:0]       cap_len,
    output logic [31:0]       sample,
    output logic              armed,
    output logic              capturing,
    output logic              done,
    output logic [15:0]       event_count
);

    localparam logic [DELTA_W-1:0] CNT_MAX = DELTA_W'(delta_max(DELTA_W));

    if (DATA_W + DELTA_W + 1 != 32) begin : g_bad_width
        $error("sample_frontend: DATA_W + DELTA_W + 1 must equal 32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("sample_frontend: SYNC_STAGES must be at least 2");
    end

    state_t              state;
    logic [DATA_W-1:0]   s;
    logic [DATA_W-1:0]   s_q;
    logic [DELTA_W-1:0]  cnt;
    logic [DATA_W-1:0]   mask_l;
    logic [DATA_W-1:0]   value_l;
    logic [15:0]         cap_len_l;
    logic                change;
    logic                trig_hit;
    logic                is_event;
    logic [15:0]         ec_inc;

    bit_sync #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (din),
        .q       (s)
    );

    function automatic logic [31:0] pack_word(
        input logic               evt,
        input logic [DELTA_W-1:0] delta,
        input logic [DATA_W-1:0]  data
    );
        logic [31:0] w;
        w                    = '0;
        w[EVT_BIT]           = evt;
        w[DATA_W +: DELTA_W] = delta;
        w[DATA_W-1:0]        = data;
        return w;
    endfunction

    assign change   = (s != s_q);
    assign trig_hit = ((s & mask_l) == (value_l & mask_l));
    assign is_event = change || (cnt == CNT_MAX);
    assign ec_inc   = event_count + 16'd1;

    // Dropping active wins over every state; it is also the mid-capture abort path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            s_q         <= '0;
            sample      <= '0;
            cnt         <= '0;
            event_count <= '0;
            mask_l      <= '0;
            value_l     <= '0;
            cap_len_l   <= '0;
        end else begin
            s_q <= s;
            if (!active) begin
                state       <= IDLE;
                sample      <= '0;
                cnt         <= '0;
                event_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sample      <= '0;
                        cnt         <= '0;
                        event_count <= '0;
                        mask_l      <= trig_mask;
                        value_l     <= trig_value;
                        cap_len_l   <= cap_len;
                        state       <= ARMED;
                    end
                    ARMED: begin
                        if (trig_hit) begin
                            sample      <= pack_word(1'b1, '0, s);
                            cnt         <= DELTA_W'(1);
                            event_count <= 16'd1;
                            state       <= (cap_len_l == 16'd1) ? DONE : CAPTURE;
                        end else begin
                            sample <= pack_word(1'b0, '0, s);
                        end
                    end
                    // A change landing on saturation still yields a single event with delta = max.
                    CAPTURE: begin
                        if (is_event) begin
                            sample      <= pack_word(1'b1, cnt, s);
                            cnt         <= DELTA_W'(1);
                            event_count <= ec_inc;
                            if ((cap_len_l != 16'd0) && (ec_inc == cap_len_l)) begin
                                state <= DONE;
                            end
                        end else begin
                            sample <= pack_word(1'b0, cnt, s);
                            cnt    <= cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        sample <= pack_word(1'b0, '0, s);
                    end
                    default: begin
                        state  <= IDLE;
                        sample <= '0;
                    end
                endcase
            end
        end
    end

    assign armed     = (state == ARMED);
    assign capturing = (state == CAPTURE);
    assign done      = (state == DONE);

endmodule
